// File: rtl/game_event_fifo_if.sv
// Consumer-side handshake of the game event FIFO: head event offered with valid, taken with ready.
// A pop happens on any clock edge where ev_valid & ev_ready; while ev_valid is high, ev_data is stable.
interface game_event_fifo_if;
    logic        ev_valid;
    logic        ev_ready;
    logic [13:0] ev_data;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/game_event_fifo.sv
// Captures WINNER/LOSER/GAMEOVER rises from the counter core, tags them with counter value and
// sequence number, and buffers them in a show-ahead FIFO with a one-entry pending slot.
module game_event_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     WINNER,
    input  logic                     LOSER,
    input  logic                     GAMEOVER,
    input  logic [1:0]               WHO,
    input  logic [3:0]               counter,
    game_event_fifo_if.master        ev,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    input  logic                     clear_overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0] typ;
        logic [3:0] cnt;
    } ev_t;

    logic          w_q, l_q, g_q;
    logic          pend_v_q, pend_v_d;
    ev_t           pend_q, pend_d;
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]    seq_q;
    logic [7:0]    drop_q, drop_d;
    logic          ovf_q, ovf_d;
    logic [13:0]   mem_q [DEPTH];

    logic          l_rise, w_rise, g_rise, g_legal, g_illegal;
    logic [1:0]    g_typ;
    logic          full, empty, pop, space, wr_en;
    logic [3:0]    cand_v;
    ev_t           cand [4];
    ev_t           first, second;
    logic [2:0]    n_cand, n_drop;
    logic [8:0]    drop_sum;

    assign l_rise    = LOSER & ~l_q;
    assign w_rise    = WINNER & ~w_q;
    assign g_rise    = GAMEOVER & ~g_q;
    assign g_legal   = g_rise & ((WHO == 2'b01) || (WHO == 2'b10));
    assign g_illegal = g_rise & ~g_legal;
    assign g_typ     = (WHO == 2'b10) ? 2'b11 : 2'b10;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop   = ~empty & ev.ev_ready;
    assign space = ~full | pop;

    assign ev.ev_valid = ~empty;
    assign ev.ev_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign level       = wr_ptr_q - rd_ptr_q;
    assign overflow    = ovf_q;
    assign drop_count  = drop_q;

    // Candidates in priority order: pending slot, LOSER, WINNER, legal GAMEOVER.
    always_comb begin
        cand_v  = {g_legal, w_rise, l_rise, pend_v_q};
        cand[0] = pend_q;
        cand[1] = {2'b00, counter};
        cand[2] = {2'b01, counter};
        cand[3] = {g_typ, counter};
        first   = '0;
        second  = '0;
        n_cand  = '0;
        for (int i = 0; i < 4; i++) begin
            if (cand_v[i]) begin
                if (n_cand == 3'd0) first = cand[i];
                else if (n_cand == 3'd1) second = cand[i];
                n_cand = n_cand + 3'd1;
            end
        end

        wr_en    = 1'b0;
        pend_v_d = 1'b0;
        pend_d   = '0;
        n_drop   = '0;
        if (space) begin
            wr_en    = (n_cand != 3'd0);
            pend_v_d = (n_cand >= 3'd2);
            pend_d   = second;
            n_drop   = (n_cand > 3'd2) ? (n_cand - 3'd2) : 3'd0;
        end else begin
            // Blocked: the oldest candidate parks (or stays) in the pending slot.
            pend_v_d = (n_cand != 3'd0);
            pend_d   = first;
            n_drop   = (n_cand > 3'd1) ? (n_cand - 3'd1) : 3'd0;
        end
        n_drop = n_drop + {2'b00, g_illegal};

        drop_sum = {1'b0, drop_q} + {6'b000000, n_drop};
        if (clear_overflow) begin
            drop_d = '0;
            ovf_d  = 1'b0;
        end else begin
            drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
            ovf_d  = ovf_q | (n_drop != 3'd0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_q      <= 1'b0;
            l_q      <= 1'b0;
            g_q      <= 1'b0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            w_q      <= WINNER;
            l_q      <= LOSER;
            g_q      <= GAMEOVER;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                seq_q    <= seq_q + 8'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage carries no reset; entries are only observable once written.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {first.typ, first.cnt, seq_q};
    end
endmodule

// File: tb/tb_game_event_fifo.sv
// Self-checking bench for game_event_fifo: scenario tasks plus a scoreboard that checks every pop
// against the events the stimulus expects to be written, in order.
module tb_game_event_fifo;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          WINNER = 1'b0;
    logic          LOSER = 1'b0;
    logic          GAMEOVER = 1'b0;
    logic [1:0]    WHO = 2'b00;
    logic [3:0]    counter = 4'd0;
    logic          clear_overflow = 1'b0;
    logic [LW-1:0] level;
    logic          overflow;
    logic [7:0]    drop_count;

    game_event_fifo_if dif ();

    game_event_fifo #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .WINNER         (WINNER),
        .LOSER          (LOSER),
        .GAMEOVER       (GAMEOVER),
        .WHO            (WHO),
        .counter        (counter),
        .ev             (dif.master),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [13:0] exp_q[$];
    logic [7:0]  exp_seq = 8'd0;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [13:0] prev_d = '0;
    logic [13:0] exp_d;

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                n_checks = n_checks + 1;
                if (dif.ev_valid !== 1'b1 || dif.ev_data !== prev_d) begin
                    n_fail = n_fail + 1;
                    $display("FAIL hold_stable: got valid=%b data=%h, required valid=1 data=%h",
                             dif.ev_valid, dif.ev_data, prev_d);
                end
            end
            if (dif.ev_valid === 1'b1 && dif.ev_ready === 1'b1) begin
                n_checks = n_checks + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL pop_unexpected: got data=%h, required no event", dif.ev_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (dif.ev_data !== exp_d) begin
                        n_fail = n_fail + 1;
                        $display("FAIL pop_data: got %h, required %h", dif.ev_data, exp_d);
                    end
                end
            end
            prev_v = dif.ev_valid;
            prev_r = dif.ev_ready;
            prev_d = dif.ev_data;
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic expect_ev(input logic [1:0] t, input logic [3:0] c);
        exp_q.push_back({t, c, exp_seq});
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic drain();
        dif.ev_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        step();
    endtask

    task automatic test_reset();
        dif.ev_ready = 1'b1;
        #1 reset_n = 1'b0;
        #10;
        n_checks = n_checks + 1;
        if (dif.ev_valid !== 1'b0 || level !== '0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_state: got valid=%b level=%0d ovf=%b drops=%0d, required 0 0 0 0",
                     dif.ev_valid, level, overflow, drop_count);
        end
        @(negedge clock);
        #1 reset_n = 1'b1;
        step();
        LOSER = 1'b1;
        counter = 4'd0;
        expect_ev(2'b00, 4'd0);
        step();
        LOSER = 1'b0;
        n_checks = n_checks + 1;
        if (dif.ev_valid !== 1'b1 || dif.ev_data !== {2'b00, 4'd0, 8'd0} || level !== LW'(1)) begin
            n_fail = n_fail + 1;
            $display("FAIL first_event: got valid=%b data=%h level=%0d, required 1 %h 1",
                     dif.ev_valid, dif.ev_data, level, {2'b00, 4'd0, 8'd0});
        end
        step();
        n_checks = n_checks + 1;
        if (dif.ev_valid !== 1'b0 || level !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL first_event_drained: got valid=%b level=%0d, required 0 0", dif.ev_valid, level);
        end
    endtask

    task automatic test_simultaneous();
        counter = 4'd0;
        step();
        LOSER = 1'b1;
        GAMEOVER = 1'b1;
        WHO = 2'b01;
        expect_ev(2'b00, 4'd0);
        expect_ev(2'b10, 4'd0);
        step();
        LOSER = 1'b0;
        GAMEOVER = 1'b0;
        n_checks = n_checks + 1;
        if (dif.ev_valid !== 1'b1 || dif.ev_data !== {2'b00, 4'd0, 8'd1}) begin
            n_fail = n_fail + 1;
            $display("FAIL simul_first: got valid=%b data=%h, required 1 %h",
                     dif.ev_valid, dif.ev_data, {2'b00, 4'd0, 8'd1});
        end
        step();
        n_checks = n_checks + 1;
        if (dif.ev_valid !== 1'b1 || dif.ev_data !== {2'b10, 4'd0, 8'd2}) begin
            n_fail = n_fail + 1;
            $display("FAIL simul_second: got valid=%b data=%h, required 1 %h",
                     dif.ev_valid, dif.ev_data, {2'b10, 4'd0, 8'd2});
        end
        step();
        n_checks = n_checks + 1;
        if (dif.ev_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL simul_end: got valid=%b ovf=%b drops=%0d, required 0 0 0",
                     dif.ev_valid, overflow, drop_count);
        end
    endtask

    task automatic test_full_backpressure();
        dif.ev_ready = 1'b0;
        counter = 4'd15;
        for (int i = 0; i <= DEPTH; i++) begin
            step();
            WINNER = 1'b1;
            expect_ev(2'b01, 4'd15);
            step();
            WINNER = 1'b0;
        end
        n_checks = n_checks + 1;
        if (level !== FULL_LVL || drop_count !== 8'd0 || overflow !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL full_parked: got level=%0d drops=%0d ovf=%b, required %0d 0 0",
                     level, drop_count, overflow, DEPTH);
        end
        step();
        WINNER = 1'b1;
        step();
        WINNER = 1'b0;
        n_checks = n_checks + 1;
        if (level !== FULL_LVL || drop_count !== 8'd1 || overflow !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL full_drop: got level=%0d drops=%0d ovf=%b, required %0d 1 1",
                     level, drop_count, overflow, DEPTH);
        end
    endtask

    task automatic test_full_with_pop();
        step();
        WINNER = 1'b1;
        dif.ev_ready = 1'b1;
        expect_ev(2'b01, 4'd15);
        step();
        WINNER = 1'b0;
        dif.ev_ready = 1'b0;
        n_checks = n_checks + 1;
        if (level !== FULL_LVL || drop_count !== 8'd1) begin
            n_fail = n_fail + 1;
            $display("FAIL full_pop: got level=%0d drops=%0d, required %0d 1", level, drop_count, DEPTH);
        end
        drain();
        n_checks = n_checks + 1;
        if (exp_q.size() != 0 || level !== '0 || overflow !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL full_drain: got left=%0d level=%0d ovf=%b, required 0 0 1",
                     exp_q.size(), level, overflow);
        end
    endtask

    task automatic test_saturation();
        step();
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        n_checks = n_checks + 1;
        if (overflow !== 1'b0 || drop_count !== 8'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL clear: got ovf=%b drops=%0d, required 0 0", overflow, drop_count);
        end
        for (int i = 0; i < 300; i++) begin
            step();
            GAMEOVER = 1'b1;
            WHO = (i % 2 == 1) ? 2'b11 : 2'b00;
            step();
            GAMEOVER = 1'b0;
            if (i == 99) begin
                n_checks = n_checks + 1;
                if (drop_count !== 8'd100 || overflow !== 1'b1) begin
                    n_fail = n_fail + 1;
                    $display("FAIL drop_100: got drops=%0d ovf=%b, required 100 1", drop_count, overflow);
                end
            end
        end
        n_checks = n_checks + 1;
        if (drop_count !== 8'd255 || overflow !== 1'b1 || level !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL saturate: got drops=%0d ovf=%b level=%0d, required 255 1 0",
                     drop_count, overflow, level);
        end
        step();
        GAMEOVER = 1'b1;
        WHO = 2'b00;
        clear_overflow = 1'b1;
        step();
        GAMEOVER = 1'b0;
        clear_overflow = 1'b0;
        n_checks = n_checks + 1;
        if (drop_count !== 8'd0 || overflow !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL clear_vs_drop: got drops=%0d ovf=%b, required 0 0", drop_count, overflow);
        end
        step();
        GAMEOVER = 1'b1;
        WHO = 2'b11;
        step();
        GAMEOVER = 1'b0;
        n_checks = n_checks + 1;
        if (drop_count !== 8'd1 || overflow !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL drop_after_clear: got drops=%0d ovf=%b, required 1 1", drop_count, overflow);
        end
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
    endtask

    task automatic test_seq_wrap();
        logic [3:0] c;
        int r;
        dif.ev_ready = 1'b1;
        WHO = 2'b10;
        for (int i = 0; i < 256; i++) begin
            step();
            r = i % 3;
            c = 4'($urandom_range(0, 15));
            counter = c;
            LOSER = (r == 0);
            WINNER = (r == 1);
            GAMEOVER = (r == 2);
            if (r == 0) expect_ev(2'b00, c);
            else if (r == 1) expect_ev(2'b01, c);
            else expect_ev(2'b11, c);
        end
        step();
        LOSER = 1'b0;
        WINNER = 1'b0;
        GAMEOVER = 1'b0;
        drain();
        n_checks = n_checks + 1;
        if (exp_q.size() != 0 || level !== '0 || overflow !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL wrap_drain: got left=%0d level=%0d ovf=%b, required 0 0 0",
                     exp_q.size(), level, overflow);
        end
    endtask

    task automatic test_reset_midstream();
        dif.ev_ready = 1'b0;
        counter = 4'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            WINNER = 1'b1;
            step();
            WINNER = 1'b0;
        end
        n_checks = n_checks + 1;
        if (level !== LW'(3) || dif.ev_valid !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL pre_reset: got level=%0d valid=%b, required 3 1", level, dif.ev_valid);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks = n_checks + 1;
        if (level !== '0 || dif.ev_valid !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL async_reset: got level=%0d valid=%b, required 0 0", level, dif.ev_valid);
        end
        exp_q.delete();
        exp_seq = 8'd0;
        @(negedge clock);
        #1 reset_n = 1'b1;
        dif.ev_ready = 1'b1;
        step();
        LOSER = 1'b1;
        counter = 4'd5;
        expect_ev(2'b00, 4'd5);
        step();
        LOSER = 1'b0;
        n_checks = n_checks + 1;
        if (dif.ev_valid !== 1'b1 || dif.ev_data !== {2'b00, 4'd5, 8'd0}) begin
            n_fail = n_fail + 1;
            $display("FAIL post_reset_seq: got valid=%b data=%h, required 1 %h",
                     dif.ev_valid, dif.ev_data, {2'b00, 4'd5, 8'd0});
        end
        drain();
        n_checks = n_checks + 1;
        if (exp_q.size() != 0 || level !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL post_reset_drain: got left=%0d level=%0d, required 0 0", exp_q.size(), level);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.ev_ready = 1'b0;
        test_reset();
        test_simultaneous();
        test_full_backpressure();
        test_full_with_pop();
        test_saturation();
        test_seq_wrap();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/game_event_fifo.md
# game_event_fifo

Downstream consumer of the counter-game core. Detects the core's WINNER, LOSER and GAMEOVER pulses, tags each event with the counter value and a sequence number, and buffers the events in a show-ahead FIFO. A display or logger stage drains the FIFO through a valid/ready handshake. Events that cannot be buffered are counted and flagged, never silently lost.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64.
- clock  in  1  rising-edge clock, shared with the counter core.
- reset_n  in  1  asynchronous, active-low reset.
- WINNER  in  1  core winner pulse.
- LOSER  in  1  core loser pulse.
- GAMEOVER  in  1  core game-over pulse.
- WHO  in  2  core game-over reason: 01 loser, 10 winner.
- counter  in  4  core counter value.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head.
- ev_data  out  14  {type[13:12], cnt[11:8], seq[7:0]}.
- level  out  $clog2(DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky; set when any event is dropped.
- drop_count  out  8  saturating count of dropped events.
- clear_overflow  in  1  synchronous clear of overflow and drop_count.

## Operation
- Edge detect: registers w_q, l_q and g_q hold the previous samples. An event is a rise, i.e. X & !X_q.
  - These registers reset to 0, so an input that is high on the first edge after reset counts as an event.
- Type encoding:
  - 00: LOSER rise.
  - 01: WINNER rise.
  - 10: GAMEOVER rise with WHO=01.
  - 11: GAMEOVER rise with WHO=10.
  - A GAMEOVER rise with WHO=00 or 11 is an illegal event: counted as a drop, overflow set.
- Snapshot: cnt = counter sampled on the same edge as the rise.
- Arbitration: at most one FIFO write per cycle. Candidates are taken in this order:
  1. the pending slot, if valid;
  2. a new LOSER rise;
  3. a new WINNER rise;
  4. a new GAMEOVER rise.
- The first candidate is written (if there is space). The second goes to the 1-entry pending slot. Any further candidates are dropped.
- No space and nothing popped this cycle: the first candidate stays in (or moves to) the pending slot, and the other candidates are dropped.
- Drops: each dropped event sets overflow and increments drop_count by 1, saturating at 255.
- clear_overflow: takes priority over a drop in the same cycle, i.e. the result is cleared. Drops in the following cycles count again.
- seq: 8-bit counter, reset value 0. It is assigned at FIFO write and increments only on a write, wrapping 255 -> 0. Dropped events consume no seq.
- FIFO: show-ahead. ev_data = mem[rd_ptr] whenever ev_valid=1.
  - A pop happens when ev_valid & ev_ready.
  - When full, a write is accepted in the same cycle as a pop.
  - When empty, a write is not bypassed to the output (see Timing).
- Handshake: once ev_valid is high, ev_data is held stable and ev_valid stays high until the pop. ev_ready may be held high permanently.
- Pointers are log2(DEPTH)+1 bits with a wrap bit:
  - full = (addresses equal, wrap bits differ);
  - empty = pointers equal;
  - level = wr_ptr - rd_ptr.

## Timing
- Reset (asynchronous assert, synchronous to clock on release): ev_valid=0, level=0, overflow=0, drop_count=0, seq=0, pending slot empty, edge registers 0. ev_data has no reset value; it is don't-care while ev_valid=0.
- Reset asserted mid-operation: all buffered and pending events are discarded immediately, with no partial pop.
- Latency:
  - A rise sampled at edge N is written at edge N, so ev_valid=1 in cycle N+1 with an empty FIFO.
  - A pending entry is written at edge N+1 at the earliest, visible in cycle N+2.
- The core can raise LOSER (or WINNER) on the same edge as GAMEOVER: LOSER is written at edge N and GAMEOVER at edge N+1. No drop occurs.
- level updates on the edge of each write or pop. A simultaneous write and pop leaves level unchanged.
- overflow and drop_count update on the edge where the drop is decided.

## Test plan
- Reset with empty FIFO:
  - Stimulus: single LOSER pulse at counter=0, ev_ready=1.
  - Response: ev_valid high for one cycle, ev_data={00,0000,0x00}, level back to 0, seq next=1.
- Simultaneous events:
  - Stimulus: LOSER and GAMEOVER (WHO=01) rise on the same edge, counter=0.
  - Response: two entries in consecutive cycles: {00,0,seq k}, then {10,0,seq k+1}. overflow stays 0.
- Full back-pressure:
  - Stimulus: ev_ready=0, DEPTH+1 WINNER pulses at counter=15, spaced 2 cycles.
  - Response: level=DEPTH, the extra event is parked in the pending slot, drop_count=0. The next pulse gives drop_count=1 and overflow=1.
- Full with pop:
  - Stimulus: FIFO full, ev_ready=1 on the same cycle as a new WINNER rise.
  - Response: pop and write both occur, level stays DEPTH, no drop.
- Saturation and clear:
  - Stimulus: 300 drops.
  - Response: drop_count=255. Then clear_overflow for one cycle gives overflow=0 and drop_count=0. A drop coincident with the clear still reads 0.
- Seq wrap and reset mid-stream:
  - Stimulus: 256 pushes.
  - Response: seq goes 255 -> 0.
  - Stimulus: assert reset_n=0 with level=3.
  - Response: ev_valid=0 and level=0 immediately. The first event after release carries seq=0.
